// File: rtl/priority_encoder_8to3_pkg.sv
// Shared widths for the 8-to-3 priority encoder slice.
package priority_encoder_8to3_pkg;
    localparam int IN_W  = 8;
    localparam int OUT_W = 3;
endpackage

// File: rtl/priority_encoder_8to3_if.sv
// Request/result bundle between a requester (master) and the encoder (slave).
interface priority_encoder_8to3_if;
    import priority_encoder_8to3_pkg::*;

    logic [IN_W-1:0]  in_i;
    logic             enable_i;
    logic [OUT_W-1:0] out_o;
    logic             valid_o;

    modport master (output in_i, output enable_i, input out_o, input valid_o);
    modport slave  (input in_i, input enable_i, output out_o, output valid_o);
endinterface

// File: rtl/priority_encoder_8to3_comb.sv
// Combinational core: index of the most significant set bit plus an any-set flag.
module prio_enc_comb_8x3
    import priority_encoder_8to3_pkg::*;
(
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] idx_o,
    output logic             any_o
);

    // Ascending scan: a higher set bit overwrites any lower one.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in_i[i]) begin
                idx_o = OUT_W'(i);
            end
        end
    end

    assign any_o = |in_i;

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with enable gating and synchronous reset.
module priority_encoder_8to3
    import priority_encoder_8to3_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    priority_encoder_8to3_if.slave bus
);

    logic [OUT_W-1:0] idx;
    logic             any;
    logic [OUT_W-1:0] out_d, out_q;
    logic             valid_d, valid_q;

    prio_enc_comb_8x3 u_comb (
        .in_i  (bus.in_i),
        .idx_o (idx),
        .any_o (any)
    );

    // Disabled or empty requests both collapse to the idle code 0 / invalid.
    always_comb begin
        out_d   = '0;
        valid_d = 1'b0;
        if (bus.enable_i && any) begin
            out_d   = idx;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_o   = out_q;
    assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench: directed scenarios plus random traffic against a log2 reference.
module tb_priority_encoder_8to3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_passed;

    priority_encoder_8to3_if bus_if ();

    priority_encoder_8to3 dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end else begin
            n_passed++;
        end
    endtask

    // Reference: floor(log2(v)) for nonzero v, gated by reset and enable.
    function automatic void ref_model(input logic r, input logic e, input logic [7:0] v,
                                      output int exp_out, output int exp_valid);
        int x;
        exp_out   = 0;
        exp_valid = 0;
        if (!r && e && v != 8'd0) begin
            x = int'(v);
            while (x > 1) begin
                x = x / 2;
                exp_out++;
            end
            exp_valid = 1;
        end
    endfunction

    // Inputs are applied 1 time unit after a rising edge, sampled at the next
    // edge, and the registered result is compared 1 time unit after that edge.
    task automatic drive_and_check(input string tag, input logic r, input logic e, input logic [7:0] v);
        int exp_out, exp_valid;
        rst             = r;
        bus_if.enable_i = e;
        bus_if.in_i     = v;
        @(posedge clk);
        #1;
        ref_model(r, e, v, exp_out, exp_valid);
        $display("%-8s rst=%0b en=%0b in=%02h -> out=%0d valid=%0b (exp %0d/%0d)",
                 tag, r, e, v, bus_if.out_o, bus_if.valid_o, exp_out, exp_valid);
        check_val({tag, "_out"}, 32'(bus_if.out_o), 32'(exp_out));
        check_val({tag, "_valid"}, 32'(bus_if.valid_o), 32'(exp_valid));
    endtask

    initial begin
        logic [7:0] sweep [8];
        logic [7:0] rv;
        logic       re, rr;
        n_checks = 0;
        n_passed = 0;
        sweep = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

        // Reset holds outputs idle despite an active full request.
        drive_and_check("rst0", 1'b1, 1'b1, 8'hFF);
        drive_and_check("rst1", 1'b1, 1'b1, 8'hFF);

        // Disabled, then enabled.
        drive_and_check("dis", 1'b0, 1'b0, 8'hFF);
        drive_and_check("en", 1'b0, 1'b1, 8'hFF);

        for (int k = 0; k < 8; k++) drive_and_check("sweep", 1'b0, 1'b1, sweep[k]);

        drive_and_check("zero", 1'b0, 1'b1, 8'h00);
        drive_and_check("one", 1'b0, 1'b1, 8'h01);

        for (int k = 0; k < 8; k++) drive_and_check("onehot", 1'b0, 1'b1, 8'(1 << k));
        drive_and_check("h81", 1'b0, 1'b1, 8'h81);
        drive_and_check("h12", 1'b0, 1'b1, 8'h12);

        // Mid-stream reset pulse while holding index 5, then resume.
        drive_and_check("pre5", 1'b0, 1'b1, 8'h20);
        drive_and_check("midrst", 1'b1, 1'b1, 8'h20);
        drive_and_check("resume", 1'b0, 1'b1, 8'h20);

        for (int k = 0; k < 300; k++) begin
            rr = ($urandom_range(0, 15) == 0);
            re = ($urandom_range(0, 3) != 0);
            rv = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
            drive_and_check("rand", rr, re, rv);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
